// File: rtl/text_pkg.sv
// Shared types for the text-mode cell fetch: cell layout, fetch FSM states, default geometry.
package text_pkg;

    localparam int COLS_DEFAULT = 80;
    localparam int ROWS_DEFAULT = 60;

    typedef struct packed {
        logic [7:0] attr;
        logic [7:0] chr;
    } cell_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_DRAIN
    } fetch_state_t;

endpackage

// File: rtl/text_row_buf.sv
// Ping-pong pair of character-row buffers: fetch writes the back half, display reads the front half.
// Latency: write lands at the clock edge; read data is registered, 1 cycle after rd_en.
// Backpressure: none; one write and one read per cycle, swap flips halves at the edge.
module text_row_buf
    import text_pkg::*;
#(
    parameter int COLS = COLS_DEFAULT,
    parameter int COLW = $clog2(COLS)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            swap,
    input  logic            wr_en,
    input  logic [COLW-1:0] wr_col,
    input  cell_t           wr_cell,
    input  logic            rd_en,
    input  logic [COLW-1:0] rd_col,
    output cell_t           rd_cell,
    output logic            front
);

    localparam int AW = $clog2(2 * COLS);

    cell_t          mem [2*COLS];
    logic [AW-1:0]  wr_idx;
    logic [AW-1:0]  rd_idx;

    // Half 0 occupies entries 0..COLS-1, half 1 the upper COLS entries.
    assign wr_idx = front ? AW'(wr_col) : AW'(wr_col) + AW'(COLS);
    assign rd_idx = front ? AW'(rd_col) + AW'(COLS) : AW'(rd_col);

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= wr_cell;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            front   <= 1'b0;
            rd_cell <= '0;
        end else begin
            if (swap) begin
                front <= ~front;
            end
            if (rd_en) begin
                rd_cell <= mem[rd_idx];
            end
        end
    end

endmodule

// File: rtl/text_fetch.sv
// Text-mode cell fetch: prefetches each character row from VRAM into a ping-pong buffer; TEXT_FETCH_SCROLL_EN adds scroll_row_i.
// Latency: first VRAM request 1 cycle after frame_i/line_i trigger; display cell lookup 1 cycle.
// Backpressure: none; VRAM accepts one read per cycle and returns data a fixed READ_LAT later.
module text_fetch
    import text_pkg::*;
#(
    parameter int          COLS      = COLS_DEFAULT,
    parameter int          ROWS      = ROWS_DEFAULT,
    parameter logic [15:0] BASE_ADDR = 16'h0000,
    parameter int          READ_LAT  = 1,
    parameter int          CORDW     = 16
) (
    input  logic                    clk,
    input  logic                    reset_i,
    input  logic signed [CORDW-1:0] sx_i,
    input  logic signed [CORDW-1:0] sy_i,
    input  logic                    de_i,
    input  logic                    line_i,
    input  logic                    frame_i,
`ifdef TEXT_FETCH_SCROLL_EN
    input  logic [7:0]              scroll_row_i,
`endif
    output logic                    vram_sel_o,
    output logic                    vram_wr_o,
    output logic [3:0]              vram_mask_o,
    output logic [15:0]             vram_addr_o,
    input  logic [15:0]             vram_data_in_i,
    output logic [15:0]             vram_data_out_o,
    output logic [7:0]              cell_char_o,
    output logic [7:0]              cell_attr_o,
    output logic                    cell_valid_o,
    output logic [2:0]              glyph_row_o,
    output logic                    underrun_o
);

    localparam int COLW = $clog2(COLS);
    localparam int TAGW = 3;
    localparam int LATW = $clog2(READ_LAT + 1);

    typedef struct packed {
        logic            vld;
        logic [TAGW-1:0] tag;
        logic [COLW-1:0] col;
    } pend_t;

    fetch_state_t    state;
    logic [COLW-1:0] col;
    logic [LATW-1:0] drain_cnt;
    logic [TAGW-1:0] tag;
    pend_t           pipe [READ_LAT];

    logic [CORDW-1:0] sx_u, sy_u, sx_col, char_row;
    logic             swap, line_start, start, busy, rd_en, wr_en;
    logic [15:0]      next_row, fetch_row, row_addr;
    cell_t            rd_cell;

    assign vram_wr_o       = 1'b0;
    assign vram_mask_o     = 4'hF;
    assign vram_data_out_o = 16'h0000;

    assign sx_u     = sx_i;
    assign sy_u     = sy_i;
    assign sx_col   = sx_u >> 3;
    assign char_row = sy_u >> 3;

    assign swap       = line_i && !sy_i[CORDW-1] && (sy_u < CORDW'(ROWS * 8)) && (sy_u[2:0] == 3'd0);
    assign line_start = swap && (char_row + CORDW'(1) < CORDW'(ROWS));
    assign start      = frame_i || line_start;
    assign busy       = (state != ST_IDLE);
    assign next_row   = frame_i ? 16'd0 : 16'(char_row + CORDW'(1));

`ifdef TEXT_FETCH_SCROLL_EN
    logic [15:0] scroll_q, scroll_now, row_sum;

    // The frame's scroll value must already apply to the row 0 fetch launched by frame_i itself.
    assign scroll_now = frame_i ? (16'(scroll_row_i) % 16'(ROWS)) : scroll_q;
    assign row_sum    = next_row + scroll_now;
    assign fetch_row  = (row_sum >= 16'(ROWS)) ? row_sum - 16'(ROWS) : row_sum;

    always_ff @(posedge clk) begin
        if (reset_i) begin
            scroll_q <= '0;
        end else if (frame_i) begin
            scroll_q <= scroll_now;
        end
    end
`else
    assign fetch_row = next_row;
`endif

    assign row_addr = BASE_ADDR + 16'(fetch_row * 16'(COLS));

    always_ff @(posedge clk) begin
        if (reset_i) begin
            state       <= ST_IDLE;
            col         <= '0;
            drain_cnt   <= '0;
            tag         <= '0;
            vram_sel_o  <= 1'b0;
            vram_addr_o <= 16'h0000;
            underrun_o  <= 1'b0;
        end else begin
            if (swap && busy) begin
                underrun_o <= 1'b1;
            end
            // A new trigger always wins; bumping the tag orphans any reads still in flight.
            if (start) begin
                state       <= ST_REQ;
                col         <= '0;
                tag         <= tag + TAGW'(1);
                vram_sel_o  <= 1'b1;
                vram_addr_o <= row_addr;
            end else if (swap && busy) begin
                state      <= ST_IDLE;
                tag        <= tag + TAGW'(1);
                vram_sel_o <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        vram_sel_o <= 1'b0;
                    end
                    ST_REQ: begin
                        if (col == COLW'(COLS - 1)) begin
                            state      <= ST_DRAIN;
                            vram_sel_o <= 1'b0;
                            drain_cnt  <= '0;
                        end else begin
                            col         <= col + COLW'(1);
                            vram_addr_o <= vram_addr_o + 16'd1;
                            vram_sel_o  <= 1'b1;
                        end
                    end
                    ST_DRAIN: begin
                        if (drain_cnt == LATW'(READ_LAT - 1)) begin
                            state <= ST_IDLE;
                        end else begin
                            drain_cnt <= drain_cnt + LATW'(1);
                        end
                    end
                    default: begin
                        state      <= ST_IDLE;
                        vram_sel_o <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Each slot rides alongside its read so the returning word knows its column and fetch.
    always_ff @(posedge clk) begin
        if (reset_i) begin
            for (int i = 0; i < READ_LAT; i++) begin
                pipe[i] <= '0;
            end
        end else begin
            pipe[0] <= '{vld: vram_sel_o, tag: tag, col: col};
            for (int i = 1; i < READ_LAT; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    assign wr_en = pipe[READ_LAT-1].vld && (pipe[READ_LAT-1].tag == tag) && !reset_i;
    assign rd_en = de_i && !sx_i[CORDW-1] && (sx_col < CORDW'(COLS));

    text_row_buf #(
        .COLS (COLS),
        .COLW (COLW)
    ) u_row_buf (
        .clk     (clk),
        .reset   (reset_i),
        .swap    (swap),
        .wr_en   (wr_en),
        .wr_col  (pipe[READ_LAT-1].col),
        .wr_cell (cell_t'(vram_data_in_i)),
        .rd_en   (rd_en),
        .rd_col  (COLW'(sx_col)),
        .rd_cell (rd_cell),
        .front   ()
    );

    assign cell_char_o = rd_cell.chr;
    assign cell_attr_o = rd_cell.attr;

    always_ff @(posedge clk) begin
        if (reset_i) begin
            cell_valid_o <= 1'b0;
            glyph_row_o  <= 3'd0;
        end else begin
            cell_valid_o <= de_i;
            glyph_row_o  <= sy_i[2:0];
        end
    end

endmodule

// File: tb/tb_text_fetch.sv
// Directed bench for text_fetch: a default instance plus a READ_LAT=3 / BASE_ADDR=16'hFFF0 instance.
module tb_text_fetch;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic signed [15:0] sx = '0, sy = '0;
    logic               de = 1'b0, line = 1'b0, frame = 1'b0;
`ifdef TEXT_FETCH_SCROLL_EN
    logic [7:0]         scroll = 8'd0;
`endif

    logic        sel_a, wr_a, valid_a, und_a;
    logic [3:0]  mask_a;
    logic [15:0] addr_a, din_a, dout_a;
    logic [7:0]  char_a, attr_a;
    logic [2:0]  glyph_a;

    logic        sel_b, wr_b, valid_b, und_b;
    logic [3:0]  mask_b;
    logic [15:0] addr_b, din_b, dout_b;
    logic [7:0]  char_b, attr_b;
    logic [2:0]  glyph_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    text_fetch dut (
        .clk(clk), .reset_i(reset), .sx_i(sx), .sy_i(sy), .de_i(de), .line_i(line), .frame_i(frame),
`ifdef TEXT_FETCH_SCROLL_EN
        .scroll_row_i(scroll),
`endif
        .vram_sel_o(sel_a), .vram_wr_o(wr_a), .vram_mask_o(mask_a), .vram_addr_o(addr_a),
        .vram_data_in_i(din_a), .vram_data_out_o(dout_a), .cell_char_o(char_a), .cell_attr_o(attr_a),
        .cell_valid_o(valid_a), .glyph_row_o(glyph_a), .underrun_o(und_a)
    );

    text_fetch #(.READ_LAT(3), .BASE_ADDR(16'hFFF0)) dut_w (
        .clk(clk), .reset_i(reset), .sx_i(sx), .sy_i(sy), .de_i(de), .line_i(line), .frame_i(frame),
`ifdef TEXT_FETCH_SCROLL_EN
        .scroll_row_i(scroll),
`endif
        .vram_sel_o(sel_b), .vram_wr_o(wr_b), .vram_mask_o(mask_b), .vram_addr_o(addr_b),
        .vram_data_in_i(din_b), .vram_data_out_o(dout_b), .cell_char_o(char_b), .cell_attr_o(attr_b),
        .cell_valid_o(valid_b), .glyph_row_o(glyph_b), .underrun_o(und_b)
    );

    // VRAM model: cell = {addr[7:0]^A5, addr[7:0]}, returned READ_LAT cycles after the request.
    function automatic logic [15:0] cell_of(input logic [15:0] a);
        return {a[7:0] ^ 8'hA5, a[7:0]};
    endfunction

    logic [15:0] a1, w1, w2, w3;
    always @(posedge clk) begin
        a1 <= addr_a;
        w1 <= addr_b;
        w2 <= w1;
        w3 <= w2;
    end
    assign din_a = cell_of(a1);
    assign din_b = cell_of(w3);

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_frame();
        frame = 1'b1;
        @(negedge clk);
        frame = 1'b0;
    endtask

    task automatic pulse_line(input int y);
        sy   = 16'(y);
        line = 1'b1;
        @(negedge clk);
        line = 1'b0;
    endtask

    task automatic read_at(input int x, input int y);
        sx = 16'(x);
        sy = 16'(y);
        de = 1'b1;
        @(negedge clk);
        de = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step(3);
        checks++; if (sel_a !== 1'b0)      begin errors++; $display("FAIL reset_sel: got %b want 0", sel_a); end
        checks++; if (addr_a !== 16'h0)    begin errors++; $display("FAIL reset_addr: got %h want 0000", addr_a); end
        checks++; if ({char_a, attr_a} !== 16'h0) begin errors++; $display("FAIL reset_cell: got %h%h want 0000", attr_a, char_a); end
        checks++; if (valid_a !== 1'b0 || glyph_a !== 3'd0) begin errors++; $display("FAIL reset_valid_glyph: got %b/%0d want 0/0", valid_a, glyph_a); end
        checks++; if (und_a !== 1'b0)      begin errors++; $display("FAIL reset_underrun: got %b want 0", und_a); end
        checks++; if (wr_a !== 1'b0 || mask_a !== 4'hF || dout_a !== 16'h0) begin errors++; $display("FAIL reset_consts: got wr=%b mask=%h dout=%h want 0/F/0000", wr_a, mask_a, dout_a); end
        reset = 1'b0;
        step(1);
    endtask

    task automatic test_fetch_sequence();
        int n = 0, nw = 0;
        logic [15:0] first = '0, last = '0, firstw = '0, lastw = '0;
        bit gap = 0, ended = 0, wr_bad = 0;
        pulse_frame();
        checks++; if (sel_a !== 1'b1) begin errors++; $display("FAIL first_req_cycle: sel got %b want 1", sel_a); end
        for (int i = 0; i < 120; i++) begin
            if (sel_a === 1'b1) begin
                if (n == 0) first = addr_a;
                else if (addr_a !== last + 16'd1 || ended) gap = 1;
                last = addr_a;
                n++;
            end else if (n > 0) begin
                ended = 1;
            end
            if (sel_b === 1'b1) begin
                if (nw == 0) firstw = addr_b;
                lastw = addr_b;
                nw++;
            end
            if (wr_a !== 1'b0 || wr_b !== 1'b0) wr_bad = 1;
            @(negedge clk);
        end
        checks++; if (n != 80)             begin errors++; $display("FAIL req_count: got %0d want 80", n); end
        checks++; if (first !== 16'h0000)  begin errors++; $display("FAIL req_first: got %h want 0000", first); end
        checks++; if (last !== 16'h004F)   begin errors++; $display("FAIL req_last: got %h want 004f", last); end
        checks++; if (gap)                 begin errors++; $display("FAIL req_contiguous: got gap=1 want 0"); end
        checks++; if (wr_bad)              begin errors++; $display("FAIL vram_wr: got nonzero want 0"); end
        checks++; if (nw != 80)            begin errors++; $display("FAIL wrap_count: got %0d want 80", nw); end
        checks++; if (firstw !== 16'hFFF0) begin errors++; $display("FAIL wrap_first: got %h want fff0", firstw); end
        checks++; if (lastw !== 16'h003F)  begin errors++; $display("FAIL wrap_last: got %h want 003f", lastw); end
    endtask

    task automatic test_wrap_contents();
        int         wcol [4] = '{0, 15, 16, 79};
        logic [7:0] wch  [4] = '{8'hF0, 8'hFF, 8'h00, 8'h3F};
        logic [7:0] wat  [4] = '{8'h55, 8'h5A, 8'hA5, 8'h9A};
        pulse_line(0);
        step(100);
        for (int i = 0; i < 4; i++) begin
            read_at(wcol[i] * 8, 0);
            checks++;
            if (char_b !== wch[i] || attr_b !== wat[i]) begin
                errors++;
                $display("FAIL wrap_cell col %0d: got %h/%h want %h/%h", wcol[i], char_b, attr_b, wch[i], wat[i]);
            end
        end
    endtask

    task automatic test_display();
        pulse_line(8);
        step(100);
        read_at(17, 9);
        checks++; if (char_a !== 8'h52 || attr_a !== 8'hF7) begin errors++; $display("FAIL disp_17_9: got %h/%h want 52/f7", char_a, attr_a); end
        checks++; if (valid_a !== 1'b1 || glyph_a !== 3'd1) begin errors++; $display("FAIL disp_valid_glyph: got %b/%0d want 1/1", valid_a, glyph_a); end
        read_at(639, 9);
        checks++; if (char_a !== 8'h9F || attr_a !== 8'h3A) begin errors++; $display("FAIL disp_col79: got %h/%h want 9f/3a", char_a, attr_a); end
        sx = 16'sd17;
        step(1);
        checks++; if (char_a !== 8'h9F || attr_a !== 8'h3A || valid_a !== 1'b0) begin errors++; $display("FAIL disp_hold: got %h/%h v=%b want 9f/3a v=0", char_a, attr_a, valid_a); end
        checks++; if (und_a !== 1'b0) begin errors++; $display("FAIL no_underrun_legal: got %b want 0", und_a); end
    endtask

    task automatic test_underrun();
        pulse_frame();
        step(100);
        pulse_line(0);
        step(1);
        pulse_line(8);
        checks++; if (und_a !== 1'b1) begin errors++; $display("FAIL underrun_set: got %b want 1", und_a); end
        checks++; if (sel_a !== 1'b1 || addr_a !== 16'h00A0) begin errors++; $display("FAIL underrun_restart: got sel=%b addr=%h want 1/00a0", sel_a, addr_a); end
        step(100);
        checks++; if (und_a !== 1'b1) begin errors++; $display("FAIL underrun_sticky: got %b want 1", und_a); end
        pulse_line(16);
        step(100);
        read_at(0, 16);
        checks++; if (char_a !== 8'hA0 || attr_a !== 8'h05) begin errors++; $display("FAIL row2_col0: got %h/%h want a0/05", char_a, attr_a); end
        read_at(40, 16);
        checks++; if (char_a !== 8'hA5 || attr_a !== 8'h00) begin errors++; $display("FAIL row2_col5: got %h/%h want a5/00", char_a, attr_a); end
    endtask

    task automatic test_reset_midfetch();
        reset = 1'b1;
        step(2);
        reset = 1'b0;
        step(1);
        pulse_frame();
        step(100);
        pulse_line(0);
        step(100);
        read_at(8, 3);
        checks++; if (char_a !== 8'h01 || attr_a !== 8'hA4) begin errors++; $display("FAIL pre_reset_read: got %h/%h want 01/a4", char_a, attr_a); end
        pulse_line(8);
        step(2);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++; if (sel_a !== 1'b0 || addr_a !== 16'h0) begin errors++; $display("FAIL midreset_req: got sel=%b addr=%h want 0/0000", sel_a, addr_a); end
        checks++; if ({char_a, attr_a, valid_a, glyph_a, und_a} !== 20'h0) begin errors++; $display("FAIL midreset_outputs: got %h/%h/%b/%0d/%b want all 0", char_a, attr_a, valid_a, glyph_a, und_a); end
        step(1);
        checks++; if (sel_a !== 1'b0) begin errors++; $display("FAIL post_reset_sel: got %b want 0", sel_a); end
        pulse_line(472);
        checks++; if (sel_a !== 1'b0) begin errors++; $display("FAIL last_row_no_fetch: got sel=%b want 0", sel_a); end
        step(2);
        read_at(8, 472);
        checks++; if (char_a !== 8'h01 || attr_a !== 8'hA4) begin errors++; $display("FAIL inflight_col1: got %h/%h want 01/a4", char_a, attr_a); end
        read_at(16, 472);
        checks++; if (char_a !== 8'h02 || attr_a !== 8'hA7) begin errors++; $display("FAIL inflight_col2: got %h/%h want 02/a7", char_a, attr_a); end
        read_at(0, 472);
        checks++; if (char_a !== 8'hA0 || attr_a !== 8'h05) begin errors++; $display("FAIL pre_reset_col0: got %h/%h want a0/05", char_a, attr_a); end
    endtask

`ifdef TEXT_FETCH_SCROLL_EN
    task automatic test_scroll();
        reset = 1'b1;
        step(2);
        reset = 1'b0;
        scroll = 8'd59;
        step(1);
        pulse_frame();
        checks++; if (sel_a !== 1'b1 || addr_a !== 16'd4720) begin errors++; $display("FAIL scroll_first: got sel=%b addr=%0d want 1/4720", sel_a, addr_a); end
        step(100);
        pulse_line(0);
        checks++; if (addr_a !== 16'd0) begin errors++; $display("FAIL scroll_row1_addr: got %0d want 0", addr_a); end
        step(100);
        read_at(0, 0);
        checks++; if (char_a !== 8'h70 || attr_a !== 8'hD5) begin errors++; $display("FAIL scroll_row0: got %h/%h want 70/d5", char_a, attr_a); end
        pulse_line(8);
        step(100);
        read_at(24, 8);
        checks++; if (char_a !== 8'h03 || attr_a !== 8'hA6) begin errors++; $display("FAIL scroll_row1: got %h/%h want 03/a6", char_a, attr_a); end
    endtask
`endif

    initial begin
        test_reset();
        test_fetch_sequence();
        test_wrap_contents();
        test_display();
        test_underrun();
        test_reset_midfetch();
`ifdef TEXT_FETCH_SCROLL_EN
        test_scroll();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/text_fetch.md
# text_fetch

Character-cell fetch stage feeding the text-mode pixel renderer. It reads one row of 16-bit cells (attribute + character code) from VRAM per character row into a ping-pong row buffer, ahead of display. During active video it returns the cell under the current pixel column to the renderer. It sits between the VRAM arbiter port and the renderer, driven by the VGA timing generator's coordinates and pulses.

## Interface
- COLS, 80: character columns per row
- ROWS, 60: character rows per frame (8-pixel-high cells)
- BASE_ADDR, 16'h0000: VRAM word address of cell (0,0)
- READ_LAT, 1: cycles from a read request to valid `vram_data_in_i` (1..4)
- CORDW, 16: width of signed timing coordinates

- clk  in  1  pixel clock; only clock
- reset_i  in  1  synchronous, active-high reset
- sx_i, sy_i  in  CORDW  signed pixel coordinates from the timing generator
- de_i  in  1  active-video enable
- line_i  in  1  one-cycle pulse at the start of every line; `sy_i` is the new line's number
- frame_i  in  1  one-cycle pulse in vertical blanking, at least COLS+READ_LAT+4 cycles before line 0
- vram_sel_o  out  1  read request strobe
- vram_wr_o  out  1  constant 0
- vram_mask_o  out  4  constant 4'hF
- vram_addr_o  out  16  cell word address
- vram_data_in_i  in  16  read data: [15:8] attribute, [7:0] character
- vram_data_out_o  out  16  constant 0
- cell_char_o  out  8  character of the column under `sx_i` (previous cycle)
- cell_attr_o  out  8  attribute of the same cell
- cell_valid_o  out  1  `de_i` delayed one cycle
- glyph_row_o  out  3  `sy_i[2:0]` delayed one cycle
- underrun_o  out  1  sticky: a buffer swap occurred while a fetch was in progress

## Operation
- Two row buffers, each COLS×16. The front buffer is read by the display; the back buffer is written by the fetch.
- `frame_i`: start fetching row 0 into the back buffer.
- `line_i` with 0 ≤ `sy_i` < ROWS*8 and `sy_i[2:0]`==0:
  - Swap front and back buffers.
  - Start fetching row r+1, where r = `sy_i`>>3. No fetch when r+1 ≥ ROWS.
- FSM states:
  - IDLE: on start, go to REQ with col=0.
  - REQ: assert `vram_sel_o`; `vram_addr_o` = BASE_ADDR + row*COLS + col; col increments each cycle. After col COLS-1, go to DRAIN.
  - DRAIN: wait READ_LAT cycles, then go to IDLE.
- Return data is written to back[col] using a READ_LAT-deep shift register that carries valid and col alongside each request.
- Address arithmetic is 16 bits and wraps modulo 2^16.
- Display read:
  - Column = `sx_i`>>3 when `de_i`. `cell_char_o`/`cell_attr_o` are registered from front[column] the next cycle.
  - When `de_i` is low, the outputs hold their last value.
- Simultaneous swap and busy fetch: the swap happens, `underrun_o` sets, and the fetch restarts at col 0 for the new row. Stale in-flight data is discarded using a fetch tag.
- A `frame_i` pulse during a fetch aborts it and restarts at row 0.
- Reset mid-fetch: FSM goes to IDLE immediately, in-flight data is discarded, and no request is issued in the cycle after reset.

## Timing
- Reset values: `vram_sel_o`=0, `vram_addr_o`=0, `cell_char_o`=0, `cell_attr_o`=0, `cell_valid_o`=0, `glyph_row_o`=0, `underrun_o`=0; front buffer index 0. Buffer RAM contents are undefined.
- The first request is issued the cycle after the trigger pulse.
- A fetch occupies COLS+READ_LAT+1 cycles. One row spans 8 line periods, so the fetch never overruns under legal timing.
- Display read latency: 1 cycle from `sx_i` to `cell_*_o`.

## Configuration
- TEXT_FETCH_SCROLL_EN defined:
  - Adds input `scroll_row_i` [7:0], sampled at `frame_i`.
  - Fetched row = (row + scroll) mod ROWS. A scroll value ≥ ROWS is taken mod ROWS.
- Undefined: no port; fetched row = row.

## Structure
- Package `text_pkg`:
  - `cell_t` packed struct {attr[7:0], chr[7:0]}
  - fetch FSM state enum
  - default COLS/ROWS localparams
- Sub-module `text_row_buf`: dual row buffer with one write port (back) and one registered read port (front), plus the swap bit.

## Test plan
- VRAM model with cell = {addr[7:0]^8'hA5, addr[7:0]}, READ_LAT=1; run a full frame -> at sx=17, sy=9, the next-cycle outputs are `cell_char_o`=8'h52 (address 82) and `cell_attr_o`=8'hF7.
- `frame_i` then wait -> exactly 80 requests, addresses 0x0000..0x004F, consecutive cycles, `vram_wr_o`=0 throughout.
- READ_LAT=3, BASE_ADDR=16'hFFF0 -> the row 0 fetch wraps to 0x0000..0x003F and buffer contents still match the model.
- Force a `line_i` with sy=8 two cycles after a fetch starts -> `underrun_o`=1 and stays 1; the restarted fetch fills row 2 correctly.
- Assert `reset_i` mid-fetch for 1 cycle -> `vram_sel_o`=0 the next cycle, all outputs at reset values, no buffer write from in-flight data.
- TEXT_FETCH_SCROLL_EN, `scroll_row_i`=59 -> display row 0 shows row 59 cells (first address 4720); display row 1 shows row 0.
